fetch_stage: RTL and testbench

- Instruction-fetch stage, directly upstream of instr_memory.
- Holds the program counter and drives the memory read address; instruction comes back combinationally the same cycle.
- Registers the returned instruction into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump redirect, stall, flush and misaligned-target halt.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      read_address,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;

  assign pc_plus4     = pc + 32'd4;
  assign read_address = pc;
  assign fsm_state    = state;

  // Redirects (jump, branch) outrank stall and flush; a bubble keeps if_id_pc_plus4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      misaligned     <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (jump) begin
            pc          <= {pc_plus4[31:28], jump_index, 2'b00};
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (branch_taken) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (branch_target[1:0] == 2'b00) begin
              pc <= branch_target;
            end else begin
              misaligned <= 1'b1;
              state      <= HALT;
            end
          end else if (stall) begin
            if (flush) begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end
          end else if (flush) begin
            pc          <= pc_plus4;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else begin
            pc             <= pc_plus4;
            if_id_instr    <= instruction;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 1'b1;
          end
        end
        HALT: begin
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small combinational instruction memory feeds
// the DUT and each scenario task checks hand-computed PC / IF/ID values.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] read_address;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misaligned;
  logic [15:0] fetch_count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .read_address  (read_address),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .misaligned    (misaligned),
    .fetch_count   (fetch_count),
    .fsm_state     (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: three program words, every other address returns A000_0000|addr.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   mem_word = 32'h8C01_0000;
      32'h4:   mem_word = 32'h8C02_0004;
      32'h8:   mem_word = 32'h0022_1820;
      default: mem_word = 32'hA000_0000 | addr;
    endcase
  endfunction

  assign instruction = mem_word(read_address);

  // Driver tasks
  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_index = 26'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (read_address !== 32'h0) begin errors++; $display("FAIL reset_raddr: got %h exp %h", read_address, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", if_id_instr, NOP); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h exp 0", if_id_pc_plus4); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b exp 0", misaligned); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", fetch_count); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", fsm_state); end
    #10;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i[3];
    exp_i[0] = 32'h8C01_0000; exp_i[1] = 32'h8C02_0004; exp_i[2] = 32'h0022_1820;
    cyc();  // BOOT edge
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h exp 0", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b exp 0", if_id_valid); end
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL boot_state: got %0d exp 1", fsm_state); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (pc !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc%0d: got %h exp %h", i, pc, 32'(4 * (i + 1))); end
      checks++; if (if_id_instr !== exp_i[i]) begin errors++; $display("FAIL seq_instr%0d: got %h exp %h", i, if_id_instr, exp_i[i]); end
      checks++; if (if_id_pc_plus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc4_%0d: got %h exp %h", i, if_id_pc_plus4, 32'(4 * (i + 1))); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b exp 1", i, if_id_valid); end
    end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL seq_cnt: got %0d exp 3", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(); cyc(); cyc();  // BOOT, fetch 0, fetch 4 -> pc=8
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pre_pc: got %h exp 8", pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc%0d: got %h exp 8", i, pc); end
      checks++; if (if_id_instr !== 32'h8C02_0004) begin errors++; $display("FAIL stall_instr%0d: got %h exp 8c020004", i, if_id_instr); end
      checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL stall_cnt%0d: got %0d exp 2", i, fetch_count); end
    end
    stall = 1'b0;
    cyc();
    checks++; if (if_id_instr !== 32'h0022_1820) begin errors++; $display("FAIL unstall_instr: got %h exp 00221820", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL unstall_pc4: got %h exp c", if_id_pc_plus4); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL unstall_cnt: got %0d exp 3", fetch_count); end
  endtask

  task automatic test_branch_redirect();
    cyc(); cyc(); cyc();  // pc C -> 10 -> 14 -> 18, count 6
    checks++; if (pc !== 32'h18) begin errors++; $display("FAIL br_pre_pc: got %h exp 18", pc); end
    branch_taken = 1'b1; branch_target = 32'h14; stall = 1'b1; flush = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL br_pc: got %h exp 14", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL br_instr: got %h exp %h", if_id_instr, NOP); end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL br_cnt: got %0d exp 6", fetch_count); end
    cyc();
    checks++; if (if_id_instr !== 32'hA000_0014) begin errors++; $display("FAIL br_capture: got %h exp a0000014", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h18) begin errors++; $display("FAIL br_capture_pc4: got %h exp 18", if_id_pc_plus4); end
    checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL br_capture_cnt: got %0d exp 7", fetch_count); end
  endtask

  task automatic test_jump();
    cyc();  // pc 18 -> 1C, count 8
    jump = 1'b1; jump_index = 26'h0; branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    idle_inputs();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL jmp_pc: got %h exp 0", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jmp_valid: got %b exp 0", if_id_valid); end
    checks++; if (if_id_pc_plus4 !== 32'h1C) begin errors++; $display("FAIL jmp_pc4_kept: got %h exp 1c", if_id_pc_plus4); end
    jump = 1'b1; jump_index = 26'h123;
    cyc();
    idle_inputs();
    checks++; if (pc !== 32'h48C) begin errors++; $display("FAIL jmp_idx_pc: got %h exp 48c", pc); end
    flush = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (pc !== 32'h490) begin errors++; $display("FAIL flush_pc: got %h exp 490", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", if_id_valid); end
    checks++; if (fetch_count !== 16'd8) begin errors++; $display("FAIL flush_cnt: got %0d exp 8", fetch_count); end
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1; branch_target = 32'h22;
    cyc();
    idle_inputs();
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b exp 1", misaligned); end
    checks++; if (pc !== 32'h490) begin errors++; $display("FAIL mis_pc: got %h exp 490", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b exp 0", if_id_valid); end
    checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL mis_state: got %0d exp 2", fsm_state); end
    jump = 1'b1; jump_index = 26'h5;
    cyc();
    idle_inputs();
    cyc();
    checks++; if (pc !== 32'h490) begin errors++; $display("FAIL halt_pc: got %h exp 490", pc); end
    checks++; if (fetch_count !== 16'd8) begin errors++; $display("FAIL halt_cnt: got %0d exp 8", fetch_count); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL halt_rst_pc: got %h exp 0", pc); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL halt_rst_mis: got %b exp 0", misaligned); end
    #10;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    cyc();  // BOOT
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    idle_inputs();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc: got %h exp fffffffc", pc); end
    cyc();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", pc); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h exp 0", if_id_pc_plus4); end
    checks++; if (if_id_instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h exp fffffffc", if_id_instr); end
    checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", fetch_count); end
  endtask

  task automatic test_async_reset_stall();
    cyc(); cyc();  // pc 0 -> 4 -> 8, count 3
    stall = 1'b1;
    cyc();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h exp 0", pc); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL arst_cnt: got %0d exp 0", fetch_count); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL arst_instr: got %h exp %h", if_id_instr, NOP); end
    idle_inputs();
    #10;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_redirect();
    test_jump();
    test_misaligned();
    test_wrap();
    test_async_reset_stall();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
